note_sample_player: RTL
=======================

# note_sample_player

Sample-playback engine that sits directly upstream of `Audio_Controller` on the DAC path. It selects one of several pre-recorded trumpet note clips stored back-to-back in a single-port synchronous ROM, fetches samples in order, and pushes each one into the controller's output FIFO using the `audio_out_allowed`/`write_audio_out` handshake. It supports one-shot or looped playback, with a clean stop and an end-of-clip pulse.

## Interface
- `ADDR_W`, 16: ROM address width.
- `SAMPLE_W`, 16: ROM sample width, signed two's complement.
- `NUM_NOTES`, 4: number of clips in ROM.
- `NOTE_LEN`, 7536: samples per clip. Clip k occupies addresses k*NOTE_LEN … k*NOTE_LEN+NOTE_LEN-1.
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `play`  in  1  start pulse; sampled only in IDLE.
- `stop`  in  1  abort playback; honoured in every state.
- `loop_en`  in  1  sampled at end of clip: 1 = wrap to clip start, 0 = finish.
- `note_sel`  in  $clog2(NUM_NOTES)  clip index; latched on accepted `play`.
- `rom_addr`  out  ADDR_W  registered ROM address.
- `rom_q`  in  SAMPLE_W  ROM data, valid one cycle after `rom_addr` is clocked.
- `audio_out_allowed`  in  1  from `Audio_Controller`.
- `write_audio_out`  out  1  to `Audio_Controller`.
- `left_channel_audio_out`  out  32  {sample, 16'b0}.
- `right_channel_audio_out`  out  32  identical to left.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on natural end of a non-looped clip.

## Operation
- FSM states: IDLE, ADDR, DATA, WRITE.
- IDLE: when `play`=1 and `stop`=0, latch `note_sel`, set offset=0, drive `rom_addr`=note_sel*NOTE_LEN, go to ADDR. A `note_sel` ≥ NUM_NOTES is clamped to NUM_NOTES-1.
- ADDR: the ROM samples `rom_addr`. Go to DATA.
- DATA: capture `rom_q` into the sample register. Go to WRITE.
- WRITE: `write_audio_out` = `audio_out_allowed` (combinational AND with the state decode). Hold in WRITE while `audio_out_allowed`=0. On the accepting cycle:
  - offset < NOTE_LEN-1: offset+1, update `rom_addr`, go to ADDR.
  - offset = NOTE_LEN-1 and `loop_en`=1: offset=0, `rom_addr`=base, go to ADDR. No `done`.
  - offset = NOTE_LEN-1 and `loop_en`=0: go to IDLE and pulse `done` next cycle.
- `stop`=1 in any non-IDLE state: next state is IDLE, `write_audio_out` is forced to 0 that cycle, and `done` is not pulsed. `stop` wins over a simultaneous `play` or a simultaneous final write.
- `play` while `busy` is ignored.
- Left and right channel outputs are updated only when entering WRITE, and hold their value in all other states, including IDLE after playback.
- Arithmetic: offset counter is ADDR_W bits. Base = note_idx*NOTE_LEN is computed at elaboration as a constant per index (no runtime multiplier). NUM_NOTES*NOTE_LEN must be ≤ 2^ADDR_W.

## Timing
- Reset values: `rom_addr`=0, `write_audio_out`=0, both channels=0, `busy`=0, `done`=0, state=IDLE.
- `play` at cycle 0 → ADDR at cycle 1 → DATA at cycle 2 → WRITE at cycle 3. The first write can occur at cycle 3.
- Minimum spacing between writes is 3 cycles (WRITE→ADDR→DATA→WRITE). Real rate is set by `audio_out_allowed`.
- `done` is high exactly one cycle, in the first IDLE cycle after the final write.
- Reset mid-playback: the next cycle is in reset state, with no partial write.

## Configuration
- `NOTE_SAMPLE_PLAYER_GAIN_EN` defined: adds input `gain_shift` [1:0]. The sample is arithmetic-right-shifted by `gain_shift` (sign-preserved) when captured in DATA.
- Not defined: no `gain_shift` port, and the sample passes unchanged.

## Structure
- Package `nsp_pkg`: state enum (IDLE, ADDR, DATA, WRITE) and default NOTE_LEN/NUM_NOTES constants.
- One sub-module `nsp_addr_gen`. It holds the latched note index and offset counter, and outputs `rom_addr` and a `last` flag. Its controls are load, increment and wrap.

## Test plan
Bench overrides NOTE_LEN=8, NUM_NOTES=4, and uses a behavioural ROM with data = address.
1. Reset, then `play` with `note_sel`=2, `loop_en`=0, `audio_out_allowed`=1 → 8 writes of samples 16…23 in channel bits [31:16]; `done` pulses once; `busy` drops.
2. Same as 1 with `audio_out_allowed` toggling 1/0 every 5 cycles → same 8 samples in order, none duplicated or dropped; each write occurs only when allowed.
3. `loop_en`=1, `note_sel`=1 → sequence 8…15, 8…15, … with no `done`. Drop `loop_en` during the 2nd pass → ends after 15 with `done`.
4. `stop` asserted in WRITE with `audio_out_allowed`=1 on the 4th sample → no write that cycle, IDLE next cycle, no `done`. A following `play` with `note_sel`=0 restarts at address 0.
5. `play` pulsed while busy, and `play`+`stop` in the same IDLE cycle → both ignored, with no change to the address sequence.
6. With `NOTE_SAMPLE_PLAYER_GAIN_EN`, `gain_shift`=2, ROM word 16'h8000 → channel output {16'hE000, 16'h0000}.

Source files
------------

// File: rtl/nsp_pkg.sv
// Shared types and default geometry for the note sample player.
package nsp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } state_e;

    localparam int NSP_NUM_NOTES = 4;
    localparam int NSP_NOTE_LEN  = 7536;

endpackage

// File: rtl/nsp_addr_gen.sv
// Address generator: holds the latched clip index and sample offset and
// drives the registered ROM address. Clip bases are elaboration-time constants.
module nsp_addr_gen
    import nsp_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int NUM_NOTES = NSP_NUM_NOTES,
    parameter int NOTE_LEN  = NSP_NOTE_LEN,
    parameter int IDX_W     = $clog2(NSP_NUM_NOTES)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic              wrap_i,
    input  logic [IDX_W-1:0]  note_sel_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              last_o
);

    logic [IDX_W-1:0]  idx_q, idx_d, sel_clamped;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Constant per-index lookup; folds to a small mux, no multiplier.
    function automatic logic [ADDR_W-1:0] base_of(input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] base;
        base = '0;
        for (int k = 0; k < NUM_NOTES; k++) begin
            if (idx == IDX_W'(k)) base = ADDR_W'(k * NOTE_LEN);
        end
        return base;
    endfunction

    generate
        if ((1 << IDX_W) > NUM_NOTES) begin : g_clamp
            assign sel_clamped = (note_sel_i > IDX_W'(NUM_NOTES - 1)) ? IDX_W'(NUM_NOTES - 1)
                                                                      : note_sel_i;
        end else begin : g_no_clamp
            assign sel_clamped = note_sel_i;
        end
    endgenerate

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        idx_d    = idx_q;
        offset_d = offset_q;
        addr_d   = addr_q;
        if (load_i) begin
            idx_d    = sel_clamped;
            offset_d = '0;
            addr_d   = base_of(sel_clamped);
        end else if (wrap_i) begin
            offset_d = '0;
            addr_d   = base_of(idx_q);
        end else if (inc_i) begin
            offset_d = offset_q + ADDR_W'(1);
            addr_d   = addr_q + ADDR_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q    <= '0;
            offset_q <= '0;
            addr_q   <= '0;
        end else begin
            idx_q    <= idx_d;
            offset_q <= offset_d;
            addr_q   <= addr_d;
        end
    end

    assign rom_addr_o = addr_q;
    assign last_o     = (offset_q == ADDR_W'(NOTE_LEN - 1));

endmodule

// File: rtl/note_sample_player.sv
// Trumpet clip playback engine feeding the Audio_Controller output FIFO.
// Optional NOTE_SAMPLE_PLAYER_GAIN_EN adds a gain_shift port (arithmetic right shift).
module note_sample_player
    import nsp_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int SAMPLE_W  = 16,
    parameter int NUM_NOTES = NSP_NUM_NOTES,
    parameter int NOTE_LEN  = NSP_NOTE_LEN
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         play,
    input  logic                         stop,
    input  logic                         loop_en,
    input  logic [$clog2(NUM_NOTES)-1:0] note_sel,
`ifdef NOTE_SAMPLE_PLAYER_GAIN_EN
    input  logic [1:0]                   gain_shift,
`endif
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [SAMPLE_W-1:0]          rom_q,
    input  logic                         audio_out_allowed,
    output logic                         write_audio_out,
    output logic [31:0]                  left_channel_audio_out,
    output logic [31:0]                  right_channel_audio_out,
    output logic                         busy,
    output logic                         done
);

    state_e              state_q, state_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d, sample_in;
    logic                done_q, done_d;
    logic                ag_load, ag_inc, ag_wrap, ag_last;

`ifdef NOTE_SAMPLE_PLAYER_GAIN_EN
    assign sample_in = $signed(rom_q) >>> gain_shift;
`else
    assign sample_in = rom_q;
`endif

    nsp_addr_gen #(
        .ADDR_W    (ADDR_W),
        .NUM_NOTES (NUM_NOTES),
        .NOTE_LEN  (NOTE_LEN),
        .IDX_W     ($clog2(NUM_NOTES))
    ) u_addr_gen (
        .clk_i      (CLOCK_50),
        .reset_i    (reset),
        .load_i     (ag_load),
        .inc_i      (ag_inc),
        .wrap_i     (ag_wrap),
        .note_sel_i (note_sel),
        .rom_addr_o (rom_addr),
        .last_o     (ag_last)
    );

    always_comb begin
        state_d         = state_q;
        sample_d        = sample_q;
        done_d          = 1'b0;
        ag_load         = 1'b0;
        ag_inc          = 1'b0;
        ag_wrap         = 1'b0;
        write_audio_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (play && !stop) begin
                    ag_load = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = stop ? IDLE : DATA;
            DATA: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    sample_d = sample_in;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                // stop and a pending reset both suppress the handshake so no partial write escapes.
                if (stop) begin
                    state_d = IDLE;
                end else if (audio_out_allowed && !reset) begin
                    write_audio_out = 1'b1;
                    if (!ag_last) begin
                        ag_inc  = 1'b1;
                        state_d = ADDR;
                    end else if (loop_en) begin
                        ag_wrap = 1'b1;
                        state_d = ADDR;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            sample_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign busy                    = (state_q != IDLE);
    assign done                    = done_q;
    assign left_channel_audio_out  = {sample_q, {(32 - SAMPLE_W){1'b0}}};
    assign right_channel_audio_out = {sample_q, {(32 - SAMPLE_W){1'b0}}};

endmodule
